// File: rtl/ysyx_22041752_icache_cmp.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module      : ysyx_22041752_icache_cmp
// Description : ICACHE compare stage. Holds the captured fetch address, checks
//               the tag/valid arrays and selects the instruction from the
//               SRAM read data. On a miss it refills the 16-byte line with two
//               64-bit beats, writes the SRAMs and then returns the word.
//               Optional feature macro: YSYX_22041752_ICACHE_FENCEI_EN adds the
//               fence_i port, which invalidates every line.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module ysyx_22041752_icache_cmp #(
  parameter int ADDR_W = 64,
  parameter int TAG_W  = ADDR_W - 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rs_to_cs_valid,
  input  logic [ADDR_W+3:0] rs_to_cs_bus,
  output logic              cmp_allowin,
  input  logic [63:0]       sram_rdata0,
  input  logic [63:0]       sram_rdata1,
  input  logic [63:0]       sram_rdata2,
  input  logic [63:0]       sram_rdata3,
  output logic [3:0]        sram_wen,
  output logic [5:0]        sram_waddr,
  output logic [63:0]       sram_wdata,
  output logic              inst_valid,
  output logic [31:0]       inst,
  input  logic              inst_ready,
  input  logic              flush,
`ifdef YSYX_22041752_ICACHE_FENCEI_EN
  input  logic              fence_i,
`endif
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic              rd_valid,
  input  logic [63:0]       rd_data,
  input  logic              rd_last
);

  typedef enum logic [1:0] {
    S_LOOKUP = 2'd0,
    S_REQ    = 2'd1,
    S_REFILL = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_cs_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [127:0]      r_valid;
  logic [TAG_W-1:0]  r_tag [128];
  logic [31:0]       r_word;
  logic              r_beat;
  logic              r_drop;

  logic [6:0]        w_index;
  logic [1:0]        w_word;
  logic [TAG_W-1:0]  w_addr_tag;
  logic              w_hit;
  logic              w_capture;
  logic              w_beat_fire;
  logic              w_fill_done;
  logic              w_busy;
  logic [63:0]       w_half;
  logic [31:0]       w_sel_word;
  logic              w_clear_all;
  logic              w_fence_drop;

  assign w_index     = r_addr[10:4];
  assign w_word      = r_addr[3:2];
  assign w_addr_tag  = r_addr[ADDR_W-1:11];
  assign w_hit       = r_cs_valid && r_valid[w_index] && (r_tag[w_index] == w_addr_tag);
  assign w_capture   = rs_to_cs_valid && cmp_allowin;
  assign w_beat_fire = (r_state == S_REFILL) && rd_valid;
  assign w_fill_done = w_beat_fire && rd_last;
  assign w_busy      = (r_state == S_REQ) || (r_state == S_REFILL);

  // word[1] picks the upper 64-bit half of the line, index[6] the SRAM bank
  assign w_half     = w_index[6] ? (w_word[1] ? sram_rdata3 : sram_rdata1)
                                 : (w_word[1] ? sram_rdata2 : sram_rdata0);
  assign w_sel_word = w_word[0] ? w_half[63:32] : w_half[31:0];

`ifdef YSYX_22041752_ICACHE_FENCEI_EN
  logic r_fence_pend;

  // An invalidate that lands mid-refill waits for the line to land, then wipes it too
  assign w_clear_all  = (fence_i && !w_busy) || (w_fill_done && (r_fence_pend || fence_i));
  assign w_fence_drop = fence_i && (r_state == S_LOOKUP);

  // Remember an invalidate request seen while a refill is in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fence_pend <= 1'b0;
    end else if (w_fill_done) begin
      r_fence_pend <= 1'b0;
    end else if (fence_i && w_busy) begin
      r_fence_pend <= 1'b1;
    end
  end
`else
  assign w_clear_all  = 1'b0;
  assign w_fence_drop = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_LOOKUP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and all outputs
  always_comb begin
    w_state_nxt = r_state;
    cmp_allowin = 1'b0;
    inst_valid  = 1'b0;
    inst        = 32'd0;
    rd_req      = 1'b0;
    rd_addr     = '0;
    sram_wen    = 4'b1111;
    sram_waddr  = 6'd0;
    sram_wdata  = 64'd0;
    case (r_state)
      S_LOOKUP: begin
        cmp_allowin = !r_cs_valid || (w_hit && inst_ready) || flush || w_fence_drop;
        if (w_hit && !flush && !w_fence_drop) begin
          inst_valid = 1'b1;
          inst       = w_sel_word;
        end
        if (r_cs_valid && !w_hit && !flush && !w_fence_drop) begin
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        rd_req  = 1'b1;
        rd_addr = {r_addr[ADDR_W-1:4], 4'b0000};
        if (rd_gnt) begin
          w_state_nxt = S_REFILL;
        end
      end
      S_REFILL: begin
        if (rd_valid) begin
          // SRAM number is {half, bank}: 0/1 low half, 2/3 high half
          sram_wen   = ~(4'b0001 << {r_beat, w_index[6]});
          sram_waddr = w_index[5:0];
          sram_wdata = rd_data;
          if (rd_last) begin
            w_state_nxt = (r_drop || flush) ? S_LOOKUP : S_RESP;
          end
        end
      end
      S_RESP: begin
        cmp_allowin = inst_ready || flush;
        inst_valid  = !flush;
        inst        = flush ? 32'd0 : r_word;
        if (inst_ready || flush) begin
          w_state_nxt = S_LOOKUP;
        end
      end
      default: w_state_nxt = S_LOOKUP;
    endcase
  end

  // Capture the read-stage bus; retire the entry once served or redirected
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cs_valid <= 1'b0;
      r_addr     <= '0;
    end else if (w_capture) begin
      r_cs_valid <= |rs_to_cs_bus[3:0];
      r_addr     <= rs_to_cs_bus[ADDR_W+3:4];
    end else if (r_state == S_LOOKUP && (flush || w_fence_drop || (w_hit && inst_ready))) begin
      r_cs_valid <= 1'b0;
    end else if (r_state != S_LOOKUP && w_state_nxt == S_LOOKUP) begin
      r_cs_valid <= 1'b0;
    end
  end

  // Refill bookkeeping: beat number, requested word, dropped-result flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_beat <= 1'b0;
      r_word <= 32'd0;
      r_drop <= 1'b0;
    end else begin
      if (w_beat_fire) begin
        r_beat <= rd_last ? 1'b0 : ~r_beat;
        if (w_word[1] == r_beat) begin
          r_word <= w_word[0] ? rd_data[63:32] : rd_data[31:0];
        end
      end
      if (w_fill_done) begin
        r_drop <= 1'b0;
      end else if (w_busy && flush) begin
        r_drop <= 1'b1;
      end
    end
  end

  // Valid bits: set when a line lands, cleared by reset or invalidate
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (w_clear_all) begin
      r_valid <= '0;
    end else if (w_fill_done) begin
      r_valid[w_index] <= 1'b1;
    end
  end

  // Tag array needs no reset: entries are qualified by the valid bits
  always_ff @(posedge clk) begin
    if (w_fill_done) begin
      r_tag[w_index] <= w_addr_tag;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041752_icache_cmp.sv
`timescale 1ns/1ps
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_ysyx_22041752_icache_cmp
// Description : Bench for the ICACHE compare stage with SRAM and memory-bus
//               models; expected instructions, SRAM writes and line requests
//               are queued at stimulus time and compared against the monitor.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ysyx_22041752_icache_cmp;

  logic        clk = 1'b0;
  logic        reset;
  logic        rs_to_cs_valid;
  logic [67:0] rs_to_cs_bus;
  logic        cmp_allowin;
  logic [63:0] sram_rdata0, sram_rdata1, sram_rdata2, sram_rdata3;
  logic [3:0]  sram_wen;
  logic [5:0]  sram_waddr;
  logic [63:0] sram_wdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic        inst_ready;
  logic        flush;
`ifdef YSYX_22041752_ICACHE_FENCEI_EN
  logic        fence_i;
`endif
  logic        rd_req;
  logic [63:0] rd_addr;
  logic        rd_gnt;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic        rd_last;

  int checks   = 0;
  int failures = 0;
  int gnt_delay = 2;
  bit junk_before_gnt = 1'b0;

  logic [31:0] exp_q[$], got_q[$];
  logic [73:0] exp_wen_q[$], got_wen_q[$];
  logic [63:0] exp_req_q[$], got_req_q[$];

  logic [63:0] mem [4][64];
  logic [63:0] rdat [4];
  logic [63:0] resp_line;

  always #5 clk = ~clk;

  ysyx_22041752_icache_cmp dut (
    .clk(clk), .reset(reset),
    .rs_to_cs_valid(rs_to_cs_valid), .rs_to_cs_bus(rs_to_cs_bus), .cmp_allowin(cmp_allowin),
    .sram_rdata0(sram_rdata0), .sram_rdata1(sram_rdata1),
    .sram_rdata2(sram_rdata2), .sram_rdata3(sram_rdata3),
    .sram_wen(sram_wen), .sram_waddr(sram_waddr), .sram_wdata(sram_wdata),
    .inst_valid(inst_valid), .inst(inst), .inst_ready(inst_ready), .flush(flush),
`ifdef YSYX_22041752_ICACHE_FENCEI_EN
    .fence_i(fence_i),
`endif
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last)
  );

  assign sram_rdata0 = rdat[0];
  assign sram_rdata1 = rdat[1];
  assign sram_rdata2 = rdat[2];
  assign sram_rdata3 = rdat[3];

  // Memory content: the test-plan line at 0x8000_0000, elsewhere word = its address
  function automatic logic [31:0] exp_word(input logic [63:0] a);
    if ({a[63:4], 4'b0000} == 64'h0000_0000_8000_0000) begin
      case (a[3:2])
        2'd0:    return 32'h3333_4444;
        2'd1:    return 32'h1111_2222;
        2'd2:    return 32'h7777_8888;
        default: return 32'h5555_6666;
      endcase
    end
    return {a[31:2], 2'b00};
  endfunction

  // SRAM model: write on active-low enable, read data registered and held
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (!sram_wen[k]) mem[k][sram_waddr] <= sram_wdata;
      if (rs_to_cs_valid && cmp_allowin && rs_to_cs_bus[k]) rdat[k] <= mem[k][rs_to_cs_bus[13:8]];
    end
  end

  // Memory-bus responder
  initial begin
    rd_gnt = 1'b0; rd_valid = 1'b0; rd_last = 1'b0; rd_data = 64'd0;
    forever begin
      @(posedge clk); #1;
      if (rd_req && !reset) begin
        resp_line = rd_addr;
        for (int i = 0; i < gnt_delay; i++) begin
          if (junk_before_gnt && i == 0) begin
            rd_valid = 1'b1; rd_last = 1'b1; rd_data = 64'hDEAD_BEEF_DEAD_BEEF;
          end
          @(posedge clk); #1;
          rd_valid = 1'b0; rd_last = 1'b0; rd_data = 64'd0;
        end
        rd_gnt = 1'b1;
        @(posedge clk); #1;
        rd_gnt = 1'b0;
        for (int n = 0; n < 2; n++) begin
          rd_valid = 1'b1;
          rd_last  = (n == 1);
          rd_data  = {exp_word(resp_line + 64'(8*n + 4)), exp_word(resp_line + 64'(8*n))};
          @(posedge clk); #1;
        end
        rd_valid = 1'b0; rd_last = 1'b0; rd_data = 64'd0;
      end
    end
  end

  // Monitor: collect delivered instructions, SRAM writes, granted requests
  always @(negedge clk) begin
    if (!reset) begin
      if (inst_valid && inst_ready) got_q.push_back(inst);
      if (sram_wen != 4'b1111) got_wen_q.push_back({sram_wen, sram_waddr, sram_wdata});
      if (rd_req && rd_gnt) got_req_q.push_back(rd_addr);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_queues();
    exp_q.delete(); got_q.delete(); exp_wen_q.delete(); got_wen_q.delete();
    exp_req_q.delete(); got_req_q.delete();
  endtask

  // Drive one fetch and hold it until the stage accepts it
  task automatic issue(input logic [63:0] a, input bit expect_out, output int waits);
    rs_to_cs_valid = 1'b1;
    rs_to_cs_bus   = {a, (a[10] ? 4'b1010 : 4'b0101)};
    if (expect_out) exp_q.push_back(exp_word(a));
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!cmp_allowin && waits < 300);
    @(posedge clk); #1;
    rs_to_cs_valid = 1'b0;
    rs_to_cs_bus   = '0;
  endtask

  // Let outstanding work finish (bounded)
  task automatic drain();
    int c = 0;
    while (got_q.size() < exp_q.size() && c < 200) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic expect_line(input logic [63:0] line, input logic [3:0] wen0, input logic [3:0] wen1);
    exp_req_q.push_back(line);
    exp_wen_q.push_back({wen0, 6'd0, exp_word(line + 64'd4),  exp_word(line)});
    exp_wen_q.push_back({wen1, 6'd0, exp_word(line + 64'd12), exp_word(line + 64'd8)});
  endtask

  task automatic test_reset();
    reset = 1'b1; rs_to_cs_valid = 1'b0; rs_to_cs_bus = '0; inst_ready = 1'b1; flush = 1'b0;
`ifdef YSYX_22041752_ICACHE_FENCEI_EN
    fence_i = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if ({cmp_allowin, inst_valid, rd_req, sram_wen} !== 7'b1001111) begin
      failures++;
      $display("FAIL reset_ctrl: allowin/ivalid/rdreq/wen=%b want 1001111", {cmp_allowin, inst_valid, rd_req, sram_wen});
    end
    checks++;
    if (inst !== 32'd0 || rd_addr !== 64'd0 || sram_waddr !== 6'd0 || sram_wdata !== 64'd0) begin
      failures++;
      $display("FAIL reset_data: inst=%h rd_addr=%h waddr=%h wdata=%h want all 0", inst, rd_addr, sram_waddr, sram_wdata);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    clear_queues();
  endtask

  task automatic test_cold_miss();
    int w;
    gnt_delay = 2;
    expect_line(64'h8000_0000, 4'b1110, 4'b1011);
    issue(64'h8000_0008, 1'b1, w);
    drain();
    foreach (exp_req_q[i]) begin checks++; if (i >= got_req_q.size() || got_req_q[i] !== exp_req_q[i]) begin failures++; $display("FAIL cold_rd_addr[%0d]: got %h want %h", i, (i < got_req_q.size()) ? got_req_q[i] : 64'hx, exp_req_q[i]); end end
    foreach (exp_wen_q[i]) begin checks++; if (i >= got_wen_q.size() || got_wen_q[i] !== exp_wen_q[i]) begin failures++; $display("FAIL cold_sram_write[%0d]: got %h want %h", i, (i < got_wen_q.size()) ? got_wen_q[i] : 74'hx, exp_wen_q[i]); end end
    foreach (exp_q[i]) begin checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin failures++; $display("FAIL cold_inst[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]); end end
    checks++;
    if (got_q.size() != exp_q.size() || got_wen_q.size() != exp_wen_q.size() || got_req_q.size() != exp_req_q.size()) begin
      failures++; $display("FAIL cold_counts: inst %0d/%0d wr %0d/%0d req %0d/%0d", got_q.size(), exp_q.size(), got_wen_q.size(), exp_wen_q.size(), got_req_q.size(), exp_req_q.size());
    end
    clear_queues();
  endtask

  task automatic test_hit();
    int w;
    issue(64'h8000_000C, 1'b1, w);
    @(negedge clk);
    checks++;
    if (inst_valid !== 1'b1 || inst !== 32'h5555_6666) begin
      failures++; $display("FAIL hit_latency: valid=%b inst=%h want 1 55556666", inst_valid, inst);
    end
    drain();
    foreach (exp_q[i]) begin checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin failures++; $display("FAIL hit_inst[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]); end end
    checks++;
    if (got_req_q.size() != 0 || got_q.size() != 1) begin
      failures++; $display("FAIL hit_counts: rd_req %0d want 0, insts %0d want 1", got_req_q.size(), got_q.size());
    end
    clear_queues();
  endtask

  task automatic test_back_to_back();
    int w;
    int total = 0;
    for (int i = 0; i < 4; i++) begin
      issue(64'h8000_0000 + 64'(4*i), 1'b1, w);
      total += w;
    end
    drain();
    checks++;
    if (total !== 4) begin
      failures++; $display("FAIL b2b_throughput: accept cycles %0d want 4", total);
    end
    foreach (exp_q[i]) begin checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_inst[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]); end end
    checks++;
    if (got_req_q.size() != 0 || got_q.size() != 4) begin
      failures++; $display("FAIL b2b_counts: rd_req %0d want 0, insts %0d want 4", got_req_q.size(), got_q.size());
    end
    clear_queues();
  endtask

  task automatic test_conflict();
    int w;
    gnt_delay = 3;
    junk_before_gnt = 1'b1;
    expect_line(64'h8000_0800, 4'b1110, 4'b1011);
    issue(64'h8000_0800, 1'b1, w);
    drain();
    expect_line(64'h8000_0000, 4'b1110, 4'b1011);
    issue(64'h8000_0000, 1'b1, w);
    drain();
    junk_before_gnt = 1'b0;
    gnt_delay = 2;
    foreach (exp_req_q[i]) begin checks++; if (i >= got_req_q.size() || got_req_q[i] !== exp_req_q[i]) begin failures++; $display("FAIL conflict_rd_addr[%0d]: got %h want %h", i, (i < got_req_q.size()) ? got_req_q[i] : 64'hx, exp_req_q[i]); end end
    foreach (exp_wen_q[i]) begin checks++; if (i >= got_wen_q.size() || got_wen_q[i] !== exp_wen_q[i]) begin failures++; $display("FAIL conflict_sram_write[%0d]: got %h want %h", i, (i < got_wen_q.size()) ? got_wen_q[i] : 74'hx, exp_wen_q[i]); end end
    foreach (exp_q[i]) begin checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin failures++; $display("FAIL conflict_inst[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]); end end
    checks++;
    if (got_q.size() != exp_q.size() || got_wen_q.size() != exp_wen_q.size() || got_req_q.size() != exp_req_q.size()) begin
      failures++; $display("FAIL conflict_counts: inst %0d/%0d wr %0d/%0d req %0d/%0d", got_q.size(), exp_q.size(), got_wen_q.size(), exp_wen_q.size(), got_req_q.size(), exp_req_q.size());
    end
    clear_queues();
  endtask

  task automatic test_index64();
    int w;
    expect_line(64'h8000_0400, 4'b1101, 4'b0111);
    issue(64'h8000_0400, 1'b1, w);
    drain();
    issue(64'h8000_0404, 1'b1, w);
    issue(64'h8000_040C, 1'b1, w);
    drain();
    foreach (exp_req_q[i]) begin checks++; if (i >= got_req_q.size() || got_req_q[i] !== exp_req_q[i]) begin failures++; $display("FAIL idx64_rd_addr[%0d]: got %h want %h", i, (i < got_req_q.size()) ? got_req_q[i] : 64'hx, exp_req_q[i]); end end
    foreach (exp_wen_q[i]) begin checks++; if (i >= got_wen_q.size() || got_wen_q[i] !== exp_wen_q[i]) begin failures++; $display("FAIL idx64_sram_write[%0d]: got %h want %h", i, (i < got_wen_q.size()) ? got_wen_q[i] : 74'hx, exp_wen_q[i]); end end
    foreach (exp_q[i]) begin checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin failures++; $display("FAIL idx64_inst[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]); end end
    checks++;
    if (got_q.size() != exp_q.size() || got_wen_q.size() != exp_wen_q.size() || got_req_q.size() != exp_req_q.size()) begin
      failures++; $display("FAIL idx64_counts: inst %0d/%0d wr %0d/%0d req %0d/%0d", got_q.size(), exp_q.size(), got_wen_q.size(), exp_wen_q.size(), got_req_q.size(), exp_req_q.size());
    end
    clear_queues();
  endtask

  task automatic test_stall();
    int w;
    inst_ready = 1'b0;
    issue(64'h8000_0408, 1'b1, w);
    rs_to_cs_valid = 1'b1;
    rs_to_cs_bus   = {64'h8000_0000, 4'b0101};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (inst_valid !== 1'b1 || inst !== 32'h8000_0408 || cmp_allowin !== 1'b0) begin
        failures++; $display("FAIL stall_hold[%0d]: valid=%b inst=%h allowin=%b want 1 80000408 0", c, inst_valid, inst, cmp_allowin);
      end
    end
    @(posedge clk); #1;
    inst_ready = 1'b1;
    issue(64'h8000_0000, 1'b1, w);
    drain();
    foreach (exp_q[i]) begin checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin failures++; $display("FAIL stall_inst[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]); end end
    checks++;
    if (got_q.size() != 2 || got_req_q.size() != 0) begin
      failures++; $display("FAIL stall_counts: insts %0d want 2, rd_req %0d want 0", got_q.size(), got_req_q.size());
    end
    clear_queues();
  endtask

  task automatic test_flush();
    int w;
    int seen = 0;
    int c = 0;
    // Redirect while a miss is being detected: no refill is started
    issue(64'h8000_2000, 1'b0, w);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drain();
    checks++;
    if (got_req_q.size() != 0 || got_q.size() != 0) begin
      failures++; $display("FAIL flush_lookup: rd_req %0d insts %0d want 0 0", got_req_q.size(), got_q.size());
    end
    clear_queues();
    // Redirect during the refill: line installed, no instruction returned
    expect_line(64'h8000_1000, 4'b1110, 4'b1011);
    issue(64'h8000_1000, 1'b0, w);
    while (!(rd_req && rd_gnt) && c < 100) begin @(negedge clk); c++; end
    checks++;
    if (c >= 100) begin failures++; $display("FAIL flush_gnt_wait: grant wait timed out after %0d cycles", c); end
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int k = 0; k < 8; k++) begin @(negedge clk); if (inst_valid) seen++; end
    checks++;
    if (seen != 0 || cmp_allowin !== 1'b1) begin
      failures++; $display("FAIL flush_refill: inst_valid cycles %0d allowin=%b want 0 1", seen, cmp_allowin);
    end
    @(posedge clk); #1;
    issue(64'h8000_1004, 1'b1, w);
    drain();
    foreach (exp_wen_q[i]) begin checks++; if (i >= got_wen_q.size() || got_wen_q[i] !== exp_wen_q[i]) begin failures++; $display("FAIL flush_sram_write[%0d]: got %h want %h", i, (i < got_wen_q.size()) ? got_wen_q[i] : 74'hx, exp_wen_q[i]); end end
    foreach (exp_q[i]) begin checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin failures++; $display("FAIL flush_rehit_inst[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]); end end
    checks++;
    if (got_req_q.size() != 1 || got_q.size() != 1) begin
      failures++; $display("FAIL flush_counts: rd_req %0d want 1, insts %0d want 1", got_req_q.size(), got_q.size());
    end
    clear_queues();
  endtask

`ifdef YSYX_22041752_ICACHE_FENCEI_EN
  task automatic test_fence();
    int w;
    int c = 0;
    fence_i = 1'b1;
    @(posedge clk); #1;
    fence_i = 1'b0;
    exp_req_q.push_back(64'h8000_1000);
    issue(64'h8000_1004, 1'b1, w);
    drain();
    // Invalidate arriving mid-refill also wipes the line being filled
    exp_req_q.push_back(64'h8000_0400);
    issue(64'h8000_0400, 1'b1, w);
    while (!(rd_req && rd_gnt) && c < 100) begin @(negedge clk); c++; end
    @(posedge clk); #1;
    fence_i = 1'b1;
    @(posedge clk); #1;
    fence_i = 1'b0;
    drain();
    exp_req_q.push_back(64'h8000_0400);
    issue(64'h8000_0404, 1'b1, w);
    drain();
    foreach (exp_req_q[i]) begin checks++; if (i >= got_req_q.size() || got_req_q[i] !== exp_req_q[i]) begin failures++; $display("FAIL fence_rd_addr[%0d]: got %h want %h", i, (i < got_req_q.size()) ? got_req_q[i] : 64'hx, exp_req_q[i]); end end
    foreach (exp_q[i]) begin checks++; if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin failures++; $display("FAIL fence_inst[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 32'hx, exp_q[i]); end end
    checks++;
    if (got_req_q.size() != 3 || got_q.size() != 3) begin
      failures++; $display("FAIL fence_counts: rd_req %0d want 3, insts %0d want 3", got_req_q.size(), got_q.size());
    end
    clear_queues();
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_back_to_back();
    test_conflict();
    test_index64();
    test_stall();
    test_flush();
`ifdef YSYX_22041752_ICACHE_FENCEI_EN
    test_fence();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22041752_icache_cmp.md
# ysyx_22041752_icache_cmp

Compare stage of the instruction cache, directly downstream of the ICACHE read stage. It captures the read-stage bus, checks the tag and valid bit held in internal flop arrays, and selects the 32-bit instruction from the SRAM read data. A hit returns the instruction to IF. A miss runs a two-beat line refill from the memory bus, writes the line into the SRAMs, then returns the requested instruction. The cache is direct-mapped with 128 sets and 16-byte lines; four 64x64 SRAMs hold the data (SRAM0/2 = line bits [63:0]/[127:64] for index<64, SRAM1/3 the same for index≥64).

## Interface
- ADDR_W, 64, PC/fetch address width; bus-in width = ADDR_W+4
- TAG_W, ADDR_W-11, tag width = addr[ADDR_W-1:11]
- Ports:
  - clk  in  1  clock
  - reset  in  1  asynchronous, active-high reset
  - rs_to_cs_valid  in  1  read-stage bus valid
  - rs_to_cs_bus  in  ADDR_W+4  {inst_addr, sram_en[3:0]}; en active-high
  - cmp_allowin  out  1  this stage accepts the read-stage bus this cycle
  - sram_rdata0..3  in  64 each  SRAM read data, valid the cycle after read enable, held until next enable
  - sram_wen  out  4  active-low per-SRAM write enable
  - sram_waddr  out  6  write row = index[5:0]
  - sram_wdata  out  64  write data
  - inst_valid  out  1  instruction available to IF
  - inst  out  32  instruction
  - inst_ready  in  1  IF accepts inst
  - flush  in  1  drop the CS entry (redirect)
  - rd_req  out  1  line read request
  - rd_addr  out  ADDR_W  line-aligned address (addr[3:0]=0)
  - rd_gnt  in  1  request accepted
  - rd_valid  in  1  data beat valid
  - rd_data  in  64  beat data; beat0 = bits[63:0], beat1 = bits[127:64]
  - rd_last  in  1  final beat
  - fence_i  in  1  present only with YSYX_22041752_ICACHE_FENCEI_EN

## Operation
- CS capture:
  - On rs_to_cs_valid && cmp_allowin, latch addr and en.
  - cs_valid <= |en; an all-zero en is a bubble.
- Index and offset decode:
  - index = addr[10:4].
  - word = addr[3:2]; word[1] selects the upper SRAM, word[0] selects the 32-bit half.
- Hit = cs_valid && valid[index] && tag[index]==addr[ADDR_W-1:11].
- State LOOKUP:
  - On hit: inst_valid=1, inst = selected word.
  - On miss (cs_valid && !hit && !flush): go to REQ.
- State REQ:
  - rd_req=1, rd_addr = {addr[ADDR_W-1:4],4'b0}.
  - On rd_gnt, go to REFILL.
- State REFILL, per rd_valid beat n:
  - Assert sram_wen low on the SRAM for half n and the index MSB; waddr = index[5:0]; wdata = rd_data.
  - Capture the requested word if it falls in this beat.
  - On rd_last: set valid[index]=1, write tag[index], go to RESP.
- State RESP:
  - inst_valid=1 with the captured word.
  - On inst_ready, go to LOOKUP with cs_valid=0.
- cmp_allowin:
  - LOOKUP: = !cs_valid || (hit && inst_ready) || flush.
  - RESP: = inst_ready || flush.
  - All other states: 0.
- flush:
  - In LOOKUP/RESP: clears cs_valid, inst_valid forced 0.
  - In REQ/REFILL: refill completes and the line is installed; the result is dropped and the FSM returns to LOOKUP, skipping RESP.
- A miss with rd_valid while in REQ is a protocol error; beats are ignored until rd_gnt.

## Timing
- Reset (async) values:
  - state=LOOKUP, cs_valid=0, all valid bits 0.
  - inst_valid=0, rd_req=0, sram_wen=4'b1111, cmp_allowin=1.
  - All data outputs 0.
- Hit latency: inst_valid in the cycle after capture (same cycle SRAM data returns). Back-to-back hits sustain 1 inst/cycle.
- Stalls:
  - inst_ready=0 holds inst stable.
  - cmp_allowin=0 prevents new SRAM reads, so sram_rdata stays valid.
- Miss latency: 1 (detect) + REQ wait + beats + 1 RESP cycle.
- rd_req holds high until rd_gnt and is never withdrawn.
- Tag/valid arrays update at the rd_last edge. A same-index lookup captured afterwards hits.

## Configuration
- YSYX_22041752_ICACHE_FENCEI_EN:
  - Defined: fence_i port exists. A fence_i pulse in LOOKUP clears all 128 valid bits on the next edge and drops the CS entry.
  - If fence_i arrives in REQ/REFILL, the clear is deferred until the refill finishes, and the refilled line is invalidated too.
  - Undefined: no port, and valid bits are cleared only by reset.

## Test plan
- Cold miss:
  - Stimulus: addr 0x8000_0008, en=4'b0101; memory returns beat0=0x1111_2222_3333_4444, beat1=0x5555_6666_7777_8888.
  - Response: rd_addr=0x8000_0000; sram_wen=4'b1110 then 4'b1011, waddr=0; RESP inst=0x7777_8888.
- Re-access 0x8000_000C: hit, inst=0x5555_6666 one cycle after capture, no rd_req.
- Conflict: 0x8000_0800 (index 0, different tag) → miss, refill; re-access 0x8000_0000 → miss again.
- Index 64 (addr 0x8000_0400): refill writes sram_wen=4'b1101 then 4'b0111.
- Stall and redirect:
  - inst_ready=0 for 3 cycles on a hit: inst stable, cmp_allowin=0.
  - flush during REFILL: no inst_valid, line valid afterwards.
- With YSYX_22041752_ICACHE_FENCEI_EN defined: fence_i after a fill → the next access to the same line misses.
